syst_array_feeder: RTL and testbench

//  Transmit side of the systolic DFT array input interface (x / one-hot valid_x / enable).

---
 rtl/syst_pkg.sv | 30 +++
 rtl/syst_skid_fifo.sv | 73 +++++++
 rtl/syst_array_feeder.sv | 149 ++++++++++++++
 tb/tb_syst_array_feeder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/syst_pkg.sv
// Shared definitions for the systolic DFT array and its sample feeder:
// issue-decision encoding, frame-position counter width and the
// position-to-slot one-hot mapping (first sample of a frame -> MSB).
package syst_pkg;

    // Widest frame the one-hot helper can express.
    localparam int ONEHOT_MAX = 32;

    // Per-edge feeder decision.
    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_ISSUE,
        MODE_HOLD,
        MODE_STARVE
    } feed_mode_e;

    // Width of the frame-position counter (at least one bit).
    function automatic int pos_width(input int frame_len);
        return (frame_len <= 2) ? 1 : $clog2(frame_len);
    endfunction

    // Slot for frame position pos: position 0 maps to bit frame_len-1.
    function automatic logic [ONEHOT_MAX-1:0] pos2onehot(
        input logic [ONEHOT_MAX-1:0] pos,
        input logic [ONEHOT_MAX-1:0] frame_len
    );
        return ONEHOT_MAX'(1) << (frame_len - ONEHOT_MAX'(1) - pos);
    endfunction

endpackage

// File: rtl/syst_skid_fifo.sv
// Two-entry FIFO between the sample source and the feeder issue logic.
// Empty and ready (= not full) are registered; ready resets low so the
// source sees no acceptance until the first edge after reset release.
module syst_skid_fifo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             ready
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             ready_q, ready_d;

    // Next pointers, occupancy and flags; push+pop together keeps occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        empty_d = (cnt_d == 2'd0);
        ready_d = (cnt_d != 2'd2);
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            empty_q  <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= empty_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset: contents are only read while non-empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = empty_q;
    assign ready = ready_q;

endmodule

// File: rtl/syst_array_feeder.sv
// Transmit side of the systolic DFT array input interface. Buffers a
// valid/ready sample stream and places each sample in its frame slot on
// x / valid_x, dropping enable while held or starved mid-frame.
// Optional feature: define SYST_FEEDER_ALIGN_EN to carry s_last through the
// FIFO and flag/realign framing errors on align_err.
module syst_array_feeder
    import syst_pkg::*;
#(
    parameter int X_WIDTH      = 16,
    parameter int FRAME_LENGTH = 4
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic signed [X_WIDTH-1:0] s_data,
    input  logic                      s_last,
    input  logic                      hold_i,
    output logic signed [X_WIDTH-1:0] x,
    output logic [FRAME_LENGTH-1:0]   valid_x,
    output logic                      enable,
    output logic                      frame_done,
    output logic                      align_err
);

    localparam int               POS_W    = pos_width(FRAME_LENGTH);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LENGTH - 1);

`ifdef SYST_FEEDER_ALIGN_EN
    localparam int FIFO_W = X_WIDTH + 1;
`else
    localparam int FIFO_W = X_WIDTH;
`endif

    logic                      push, pop, fifo_empty;
    logic [FIFO_W-1:0]         fifo_wdata, fifo_rdata;
    logic signed [X_WIDTH-1:0] head_data;
    feed_mode_e                mode;

    logic [POS_W-1:0]          pos_q, pos_d;
    logic signed [X_WIDTH-1:0] x_q, x_d;
    logic [FRAME_LENGTH-1:0]   valid_x_q, valid_x_d;
    logic                      enable_q, enable_d;
    logic                      frame_done_q, frame_done_d;
    logic                      align_err_q, align_err_d;

    assign push = s_valid && s_ready;

`ifdef SYST_FEEDER_ALIGN_EN
    logic head_last;
    assign fifo_wdata = {s_last, s_data};
    assign head_data  = $signed(fifo_rdata[X_WIDTH-1:0]);
    assign head_last  = fifo_rdata[X_WIDTH];
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign fifo_wdata    = s_data;
    assign head_data     = $signed(fifo_rdata);
`endif

    syst_skid_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .arst  (arst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .ready (s_ready)
    );

    // Per-edge decision in priority order: issue, hold, starve, idle.
    always_comb begin
        mode = MODE_IDLE;
        if (!hold_i && !fifo_empty) begin
            mode = MODE_ISSUE;
        end else if (hold_i) begin
            mode = MODE_HOLD;
        end else if (pos_q != '0) begin
            mode = MODE_STARVE;
        end
    end

    assign pop = (mode == MODE_ISSUE);

    // Next output and position values for the chosen decision.
    always_comb begin
        pos_d        = pos_q;
        x_d          = x_q;
        valid_x_d    = valid_x_q;
        enable_d     = 1'b0;
        frame_done_d = 1'b0;
        align_err_d  = 1'b0;
        case (mode)
            MODE_ISSUE: begin
                x_d          = head_data;
                valid_x_d    = FRAME_LENGTH'(pos2onehot(ONEHOT_MAX'(pos_q),
                                                        ONEHOT_MAX'(FRAME_LENGTH)));
                enable_d     = 1'b1;
                frame_done_d = (pos_q == POS_LAST);
                pos_d        = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
`ifdef SYST_FEEDER_ALIGN_EN
                // Early end-of-frame restarts the frame; a missing one only flags.
                if (head_last && (pos_q != POS_LAST)) begin
                    align_err_d = 1'b1;
                    pos_d       = '0;
                end else if (!head_last && (pos_q == POS_LAST)) begin
                    align_err_d = 1'b1;
                end
`endif
            end
            MODE_IDLE: begin
                enable_d  = 1'b1;
                valid_x_d = '0;
            end
            default: begin
                enable_d = 1'b0;
            end
        endcase
    end

    // Output and position registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pos_q        <= '0;
            x_q          <= '0;
            valid_x_q    <= '0;
            enable_q     <= 1'b0;
            frame_done_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            x_q          <= x_d;
            valid_x_q    <= valid_x_d;
            enable_q     <= enable_d;
            frame_done_q <= frame_done_d;
            align_err_q  <= align_err_d;
        end
    end

    assign x          = x_q;
    assign valid_x    = valid_x_q;
    assign enable     = enable_q;
    assign frame_done = frame_done_q;
    assign align_err  = align_err_q;

endmodule

// File: tb/tb_syst_array_feeder.sv
// Directed bench for syst_array_feeder (X_WIDTH=16, FRAME_LENGTH=4).
module tb_syst_array_feeder;

    logic               clk;
    logic               arst;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_data;
    logic               s_last;
    logic               hold_i;
    logic signed [15:0] x;
    logic [3:0]         valid_x;
    logic               enable;
    logic               frame_done;
    logic               align_err;

    int vectors    = 0;
    int miscompares = 0;

    syst_array_feeder #(
        .X_WIDTH      (16),
        .FRAME_LENGTH (4)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .hold_i     (hold_i),
        .x          (x),
        .valid_x    (valid_x),
        .enable     (enable),
        .frame_done (frame_done),
        .align_err  (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] ex, input logic [3:0] evx,
                           input logic een, input logic efd);
        chk({tag, ".x"},          {16'h0, x},   {16'h0, ex});
        chk({tag, ".valid_x"},    32'(valid_x), 32'(evx));
        chk({tag, ".enable"},     32'(enable),  32'(een));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(efd));
    endtask

    initial begin
        arst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; hold_i = 1'b0;
        tick();
        tick();
        // Reset state
        chk_out("rst", 16'd0, 4'b0000, 1'b0, 1'b0);
        chk("rst.s_ready",   32'(s_ready),   32'd0);
        chk("rst.align_err", 32'(align_err), 32'd0);
        arst = 1'b0;
        tick();
        chk("rel.s_ready", 32'(s_ready), 32'd1);
        chk("rel.enable",  32'(enable),  32'd1);

        // Back-to-back frame 1,2,3,4
        s_valid = 1'b1; s_data = 16'sd1;
        tick();
        chk("b2b.lat.valid_x", 32'(valid_x), 32'd0);
        s_data = 16'sd2; tick(); chk_out("b2b.1", 16'd1, 4'b1000, 1'b1, 1'b0);
        s_data = 16'sd3; tick(); chk_out("b2b.2", 16'd2, 4'b0100, 1'b1, 1'b0);
        s_data = 16'sd4; tick(); chk_out("b2b.3", 16'd3, 4'b0010, 1'b1, 1'b0);
        chk("b2b.s_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b0;  tick(); chk_out("b2b.4", 16'd4, 4'b0001, 1'b1, 1'b1);
        tick();          chk_out("b2b.idle", 16'd4, 4'b0000, 1'b1, 1'b0);

        // 1,2,3 then a 3-cycle gap before 4
        s_valid = 1'b1; s_data = 16'sd1; tick();
        s_data = 16'sd2; tick(); chk_out("gap.1", 16'd1, 4'b1000, 1'b1, 1'b0);
        s_data = 16'sd3; tick(); chk_out("gap.2", 16'd2, 4'b0100, 1'b1, 1'b0);
        s_valid = 1'b0;  tick(); chk_out("gap.3", 16'd3, 4'b0010, 1'b1, 1'b0);
        tick(); chk_out("gap.s1", 16'd3, 4'b0010, 1'b0, 1'b0);
        tick(); chk_out("gap.s2", 16'd3, 4'b0010, 1'b0, 1'b0);
        s_valid = 1'b1; s_data = 16'sd4;
        tick(); chk_out("gap.s3", 16'd3, 4'b0010, 1'b0, 1'b0);
        s_valid = 1'b0;
        tick(); chk_out("gap.4", 16'd4, 4'b0001, 1'b1, 1'b1);
        tick(); chk_out("gap.idle", 16'd4, 4'b0000, 1'b1, 1'b0);

        // hold_i for 5 cycles with s_valid high: only 5 and 6 fit
        hold_i = 1'b1; s_valid = 1'b1; s_data = 16'sd5;
        tick(); chk("hold.h1.enable", 32'(enable), 32'd0);
        s_data = 16'sd6;
        tick(); chk("hold.h2.s_ready", 32'(s_ready), 32'd0);
        s_data = 16'sd7;
        tick(); tick(); tick();
        chk("hold.h5.s_ready", 32'(s_ready), 32'd0);
        chk_out("hold.h5", 16'd4, 4'b0000, 1'b0, 1'b0);
        hold_i = 1'b0;
        tick(); chk_out("hold.r1", 16'd5, 4'b1000, 1'b1, 1'b0);
        chk("hold.r1.s_ready", 32'(s_ready), 32'd1);
        tick(); chk_out("hold.r2", 16'd6, 4'b0100, 1'b1, 1'b0);

        // Asynchronous reset after two issues (7 queued) discards everything
        s_valid = 1'b0; arst = 1'b1;
        #1;
        chk_out("arst", 16'd0, 4'b0000, 1'b0, 1'b0);
        chk("arst.s_ready", 32'(s_ready), 32'd0);
        tick();
        arst = 1'b0;
        tick(); chk_out("arst.rel", 16'd0, 4'b0000, 1'b1, 1'b0);
        s_valid = 1'b1; s_data = 16'sd10; tick();
        s_data = 16'sd11; tick(); chk_out("arst.10", 16'd10, 4'b1000, 1'b1, 1'b0);
        s_data = 16'sd12; tick(); chk_out("arst.11", 16'd11, 4'b0100, 1'b1, 1'b0);
        s_data = 16'sd13; tick(); chk_out("arst.12", 16'd12, 4'b0010, 1'b1, 1'b0);
        s_valid = 1'b0;   tick(); chk_out("arst.13", 16'd13, 4'b0001, 1'b1, 1'b1);
        tick();

        // s_last marked on the third sample of a frame
        s_valid = 1'b1; s_data = 16'sd21; s_last = 1'b0; tick();
        s_data = 16'sd22; tick(); chk_out("al.21", 16'd21, 4'b1000, 1'b1, 1'b0);
        s_data = 16'sd23; s_last = 1'b1;
        tick(); chk_out("al.22", 16'd22, 4'b0100, 1'b1, 1'b0);
        s_data = 16'sd24; s_last = 1'b0;
        tick(); chk_out("al.23", 16'd23, 4'b0010, 1'b1, 1'b0);
`ifdef SYST_FEEDER_ALIGN_EN
        chk("al.23.align_err", 32'(align_err), 32'd1);
`else
        chk("al.23.align_err", 32'(align_err), 32'd0);
`endif
        s_valid = 1'b0;
        tick();
`ifdef SYST_FEEDER_ALIGN_EN
        chk_out("al.24", 16'd24, 4'b1000, 1'b1, 1'b0);
`else
        chk_out("al.24", 16'd24, 4'b0001, 1'b1, 1'b1);
`endif
        chk("al.24.align_err", 32'(align_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
